// File: rtl/ps2_keyboard_ascii.sv
// PS/2 keyboard receiver with Set-2 scan-code to ASCII translation.
// Receives 11-bit frames on PS/2 clock falling edges, tracks shift and
// break/extended prefixes, and presents the ASCII code of the held key.
module ps2_keyboard_ascii #(
  parameter int unsigned Timeout = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] asc,
  output logic       en,
  output logic       frame_err
);

  localparam int unsigned TmoW = $clog2(Timeout + 1);

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            clk_prev_q;
  logic            fall;
  logic [3:0]      bit_cnt_q;
  logic [9:0]      frame_q;
  logic [TmoW-1:0] tmo_q;
  logic [7:0]      rx_byte_q;
  logic            rx_vld_q;
  logic            rx_err_q;
  logic            frame_ok;

  logic [7:0] asc_q, asc_d;
  logic [7:0] held_q, held_d;
  logic       shift_q, shift_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic       en_q, en_d;
  logic       err_q, err_d;
  logic [7:0] mapped;

  // Set-2 make code to ASCII; letters are upper-cased while shift is held.
  function automatic logic [7:0] key_ascii(input logic [7:0] code, input logic shifted);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      8'h4E: a = 8'h2D; 8'h55: a = 8'h3D; 8'h41: a = 8'h2C; 8'h49: a = 8'h2E;
      8'h4A: a = 8'h2F; 8'h4C: a = 8'h3B;
      default: a = 8'h00;
    endcase
    if (shifted && (a >= 8'h61) && (a <= 8'h7A)) begin
      a = a - 8'h20;
    end
    return a;
  endfunction

  // Falling edge of the synchronized PS/2 clock.
  assign fall = clk_prev_q & ~clk_sync_q[1];

  // Complete frame: frame_q[0] start, [8:1] data, [9] parity; stop is on the data line now.
  assign frame_ok = ~frame_q[0] & (^frame_q[9:1]) & data_sync_q[1];

  // Two-flop synchronizers; idle-high reset avoids a false edge after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  // Bit collection, frame checking and partial-frame timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q <= 4'd0;
      frame_q   <= 10'd0;
      tmo_q     <= '0;
      rx_byte_q <= 8'h00;
      rx_vld_q  <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      rx_err_q <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= 4'd0;
          rx_byte_q <= frame_q[8:1];
          rx_vld_q  <= frame_ok;
          rx_err_q  <= ~frame_ok;
        end else begin
          // Shift in at the top so the start bit lands in bit 0 after ten bits.
          frame_q   <= {data_sync_q[1], frame_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (tmo_q == TmoW'(Timeout - 1)) begin
          bit_cnt_q <= 4'd0;
          tmo_q     <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign mapped = key_ascii(rx_byte_q, shift_q);

  // Byte interpretation: prefixes, shift tracking, make/break of mapped keys.
  always_comb begin
    asc_d   = asc_q;
    held_d  = held_q;
    shift_d = shift_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    en_d    = 1'b0;
    err_d   = rx_err_q;
    if (rx_vld_q) begin
      if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        if ((rx_byte_q == 8'h12) || (rx_byte_q == 8'h59)) begin
          shift_d = 1'b0;
        end
        if (rx_byte_q == held_q) begin
          asc_d  = 8'h00;
          held_d = 8'h00;
        end
        brk_d = 1'b0;
      end else if ((rx_byte_q == 8'h12) || (rx_byte_q == 8'h59)) begin
        shift_d = 1'b1;
      end else if (mapped != 8'h00) begin
        asc_d  = mapped;
        held_d = rx_byte_q;
        en_d   = 1'b1;
      end
    end
  end

  // Decode state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asc_q   <= 8'h00;
      held_q  <= 8'h00;
      shift_q <= 1'b0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      asc_q   <= asc_d;
      held_q  <= held_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  assign asc       = asc_q;
  assign en        = en_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Bench for ps2_keyboard_ascii: directed test-plan frames plus random frames
// checked against a table-driven keyboard model.
module tb_ps2_keyboard_ascii;

  localparam int unsigned Timeout = 600;
  localparam int          H       = 16;  // PS/2 half bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] asc;
  logic       en;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] lo_map [256];
  logic [7:0] mapped_q [$];
  logic [7:0] m_asc, m_held;
  bit         m_shift, m_brk, m_ext, m_en;

  ps2_keyboard_ascii #(.Timeout(Timeout)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .asc      (asc),
    .en       (en),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_asc = 8'h00; m_held = 8'h00; m_shift = 0; m_brk = 0; m_ext = 0; m_en = 0;
  endtask

  function automatic logic [7:0] m_map(input logic [7:0] c);
    logic [7:0] v;
    v = lo_map[c];
    if (m_shift && v >= "a" && v <= "z") v = v - 8'h20;
    return v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] a;
    a = m_map(b);
    m_en = 0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_ext) begin m_ext = 0; m_brk = 0; end
    else if (m_brk) begin
      if (b == 8'h12 || b == 8'h59) m_shift = 0;
      if (b == m_held) begin m_asc = 8'h00; m_held = 8'h00; end
      m_brk = 0;
    end
    else if (b == 8'h12 || b == 8'h59) m_shift = 1;
    else if (a != 8'h00) begin m_asc = a; m_held = b; m_en = 1; end
  endtask

  // Sends one full frame and checks the response on the exact cycle it is due.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input string tag);
    logic [10:0] f;
    logic        e_err;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    e_err = bad_par | bad_stop;
    if (e_err) m_en = 0;
    else model_byte(b);
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      cyc(H);
      ps2_clk = 1'b0;
      if (i == 10) begin
        cyc(3);
        check({tag, ".en_early"}, {7'd0, en}, 8'h00);
        check({tag, ".err_early"}, {7'd0, frame_err}, 8'h00);
        cyc(1);
        check({tag, ".en"}, {7'd0, en}, {7'd0, m_en});
        check({tag, ".err"}, {7'd0, frame_err}, {7'd0, e_err});
        check({tag, ".asc"}, asc, m_asc);
        cyc(1);
        check({tag, ".en_1cyc"}, {7'd0, en | frame_err}, 8'h00);
        cyc(H - 5);
      end else begin
        cyc(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(H);
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'b1;
      cyc(H);
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  initial begin
    logic [7:0] letters [26];
    logic [7:0] digits [10];
    logic [7:0] code;
    int         r;
    letters = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
                8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    digits  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 256; i++) lo_map[i] = 8'h00;
    for (int i = 0; i < 26; i++) lo_map[letters[i]] = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) lo_map[digits[i]] = 8'h30 + 8'(i);
    lo_map[8'h29] = 8'h20; lo_map[8'h5A] = 8'h0D; lo_map[8'h66] = 8'h08;
    lo_map[8'h4E] = "-";   lo_map[8'h55] = "=";   lo_map[8'h41] = ",";
    lo_map[8'h49] = ".";   lo_map[8'h4A] = "/";   lo_map[8'h4C] = ";";
    for (int i = 0; i < 256; i++) if (lo_map[i] != 8'h00) mapped_q.push_back(8'(i));
    model_reset();

    // Reset
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("rst.asc", asc, 8'h00);
    check("rst.en", {7'd0, en}, 8'h00);
    check("rst.err", {7'd0, frame_err}, 8'h00);

    // Make and break of 'a'
    send_frame(8'h1C, 0, 0, "a_make");
    check("tp.a", asc, 8'h61);
    send_frame(8'hF0, 0, 0, "a_f0");
    send_frame(8'h1C, 0, 0, "a_brk");
    check("tp.a_rel", asc, 8'h00);

    // Shifted 'A', release, shift release, plain 'a'
    send_frame(8'h12, 0, 0, "sh_make");
    send_frame(8'h1C, 0, 0, "A_make");
    check("tp.A", asc, 8'h41);
    send_frame(8'hF0, 0, 0, "A_f0");
    send_frame(8'h1C, 0, 0, "A_brk");
    check("tp.A_rel", asc, 8'h00);
    send_frame(8'hF0, 0, 0, "sh_f0");
    send_frame(8'h12, 0, 0, "sh_brk");
    send_frame(8'h1C, 0, 0, "a2_make");
    check("tp.a2", asc, 8'h61);

    // Bad parity and bad stop
    send_frame(8'h45, 1, 0, "bad_par");
    send_frame(8'h45, 0, 1, "bad_stop");
    check("tp.bad_asc", asc, 8'h61);

    // Extended key ignored, then space and typematic repeats
    send_frame(8'hE0, 0, 0, "ext_e0");
    send_frame(8'h75, 0, 0, "ext_75");
    send_frame(8'h29, 0, 0, "space");
    check("tp.space", asc, 8'h20);
    for (int i = 0; i < 3; i++) send_frame(8'h29, 0, 0, "space_rep");

    // Partial frame abandoned by timeout
    send_partial(4);
    cyc(Timeout + 10);
    send_frame(8'h16, 0, 0, "after_tmo");
    check("tp.tmo_1", asc, 8'h31);

    // Partial frame aborted by reset
    send_partial(4);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    model_reset();
    cyc(2);
    check("midrst.asc", asc, 8'h00);
    send_frame(8'h16, 0, 0, "after_rst");
    check("tp.rst_1", asc, 8'h31);

    // Random frames against the model
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4) code = mapped_q[$urandom_range(0, mapped_q.size() - 1)];
      else if (r == 5) code = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
      else if (r == 6) code = 8'hF0;
      else if (r == 7) code = 8'hE0;
      else code = 8'($urandom);
      send_frame(code, r == 9, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
